// File: rtl/load_store_unit_pkg.sv
// Shared types for the load/store unit store path.
//   store_width_t        : access size of a buffered store (BYTE, HALF, WORD)
//   store_buffer_entry_t : one store-buffer entry (address, data, width)
//   drain_state_t        : state of the store-buffer drain FSM
package load_store_unit_pkg;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } store_width_t;

    typedef struct packed {
        logic [31:0]  address;
        logic [31:0]  data;
        store_width_t store_width;
    } store_buffer_entry_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2
    } drain_state_t;

endpackage

// File: rtl/store_buffer_drain_if.sv
// Pull channel between the store buffer (slave) and its drain logic (master).
//   empty        : buffer has no entry; packet is valid whenever empty is low
//   packet       : head entry, first-word-fall-through
//   pull_request : pops the head entry at the rising clock edge
interface store_buffer_pull_interface;
    import load_store_unit_pkg::*;

    logic                empty;
    store_buffer_entry_t packet;
    logic                pull_request;

    modport master (input empty, input packet, output pull_request);
    modport slave  (output empty, output packet, input pull_request);

endinterface

// File: rtl/store_lane_aligner.sv
// Combinational lane alignment of a store-buffer entry onto a 32-bit bus.
//   entry_i      : entry to align
//   address_o    : word-aligned address
//   data_o       : data replicated across all byte lanes of its width
//   strobe_o     : byte enables for the addressed lanes
//   misaligned_o : access crosses its natural alignment (or width is invalid)
module store_lane_aligner
    import load_store_unit_pkg::*;
(
    input  store_buffer_entry_t entry_i,
    output logic [31:0]         address_o,
    output logic [31:0]         data_o,
    output logic [3:0]          strobe_o,
    output logic                misaligned_o
);

    always_comb begin
        address_o    = {entry_i.address[31:2], 2'b00};
        data_o       = entry_i.data;
        strobe_o     = 4'b1111;
        misaligned_o = 1'b0;
        case (entry_i.store_width)
            BYTE: begin
                strobe_o = 4'b0001 << entry_i.address[1:0];
                data_o   = {4{entry_i.data[7:0]}};
            end
            HALF: begin
                strobe_o     = 4'b0011 << entry_i.address[1:0];
                data_o       = {2{entry_i.data[15:0]}};
                misaligned_o = entry_i.address[0];
            end
            WORD: begin
                misaligned_o = |entry_i.address[1:0];
            end
            default: begin
                misaligned_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/store_buffer_drain.sv
// Drains the store buffer into memory, one store outstanding at a time.
//   clk_i, rst_n_i      : clock, synchronous active-low reset
//   pull_channel        : FWFT pull port of the store buffer
//   stall_i             : blocks new pulls while high
//   store_valid_o/ready : store request handshake
//   store_address_o     : word-aligned store address
//   store_data_o        : lane-replicated store data
//   store_strobe_o      : byte enables
//   store_done_i        : memory write completed
//   misaligned_o        : one-cycle pulse when an entry is dropped as misaligned
//   timeout_o           : one-cycle pulse when store_done_i never arrived
//   idle_o              : nothing in flight and buffer empty
module store_buffer_drain
    import load_store_unit_pkg::*;
#(
    parameter int unsigned DONE_TIMEOUT = 255
) (
    input  logic                              clk_i,
    input  logic                              rst_n_i,
    store_buffer_pull_interface.master        pull_channel,
    input  logic                              stall_i,
    output logic                              store_valid_o,
    input  logic                              store_ready_i,
    output logic [31:0]                       store_address_o,
    output logic [31:0]                       store_data_o,
    output logic [3:0]                        store_strobe_o,
    input  logic                              store_done_i,
    output logic                              misaligned_o,
    output logic                              timeout_o,
    output logic                              idle_o
);

    localparam int unsigned    CNT_W    = $clog2(DONE_TIMEOUT + 1);
    // Last count value before expiry: the edge that would bring the counter
    // to DONE_TIMEOUT is the expiry edge.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DONE_TIMEOUT - 1);

    drain_state_t     state_q;
    logic [CNT_W-1:0] count_q;
    logic             valid_q;
    logic             misaligned_q;
    logic             timeout_q;
    logic [31:0]      address_q;
    logic [31:0]      data_q;
    logic [3:0]       strobe_q;

    logic [31:0]      aligned_address;
    logic [31:0]      aligned_data;
    logic [3:0]       aligned_strobe;
    logic             aligned_misaligned;
    logic             pull;

    store_lane_aligner u_aligner (
        .entry_i      (pull_channel.packet),
        .address_o    (aligned_address),
        .data_o       (aligned_data),
        .strobe_o     (aligned_strobe),
        .misaligned_o (aligned_misaligned)
    );

    // A pop happens from IDLE, or from WAIT_DONE in the completion cycle.
    always_comb begin
        pull = 1'b0;
        if (rst_n_i && !pull_channel.empty && !stall_i) begin
            pull = (state_q == IDLE) || ((state_q == WAIT_DONE) && store_done_i);
        end
    end

    assign pull_channel.pull_request = pull;
    assign idle_o                    = (state_q == IDLE) && pull_channel.empty;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q      <= IDLE;
            count_q      <= '0;
            valid_q      <= 1'b0;
            misaligned_q <= 1'b0;
            timeout_q    <= 1'b0;
            address_q    <= '0;
            data_q       <= '0;
            strobe_q     <= '0;
        end else begin
            misaligned_q <= 1'b0;
            timeout_q    <= 1'b0;
            case (state_q)
                ISSUE: begin
                    if (store_ready_i) begin
                        valid_q <= 1'b0;
                        count_q <= '0;
                        state_q <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (store_done_i) begin
                        count_q <= '0;
                        state_q <= IDLE;
                    end else if (count_q == CNT_LAST) begin
                        timeout_q <= 1'b1;
                        count_q   <= '0;
                        state_q   <= IDLE;
                    end else begin
                        count_q <= count_q + CNT_W'(1);
                    end
                end
                default: ;
            endcase
            // The pop overrides the state chosen above, so a completion in
            // WAIT_DONE can chain straight into the next entry.
            if (pull) begin
                if (aligned_misaligned) begin
                    misaligned_q <= 1'b1;
                    valid_q      <= 1'b0;
                    state_q      <= IDLE;
                end else begin
                    valid_q   <= 1'b1;
                    address_q <= aligned_address;
                    data_q    <= aligned_data;
                    strobe_q  <= aligned_strobe;
                    state_q   <= ISSUE;
                end
            end
        end
    end

    assign store_valid_o   = valid_q;
    assign store_address_o = address_q;
    assign store_data_o    = data_q;
    assign store_strobe_o  = strobe_q;
    assign misaligned_o    = misaligned_q;
    assign timeout_o       = timeout_q;

endmodule

// File: tb/tb_store_buffer_drain.sv
module tb_store_buffer_drain;
    import load_store_unit_pkg::*;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst_n, stall, ready, done;
    logic        valid, mis, tmo, idle;
    logic [31:0] addr, data;
    logic [3:0]  strb;

    store_buffer_pull_interface pif ();

    store_buffer_drain #(.DONE_TIMEOUT(TO)) dut (
        .clk_i           (clk),
        .rst_n_i         (rst_n),
        .pull_channel    (pif.master),
        .stall_i         (stall),
        .store_valid_o   (valid),
        .store_ready_i   (ready),
        .store_address_o (addr),
        .store_data_o    (data),
        .store_strobe_o  (strb),
        .store_done_i    (done),
        .misaligned_o    (mis),
        .timeout_o       (tmo),
        .idle_o          (idle)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
    } exp_t;

    store_buffer_entry_t fifo[$];
    exp_t                expq[$];
    int                  checks = 0;
    int                  errors = 0;
    int unsigned         pulls  = 0;

    logic        s_pull, s_valid, s_mis, s_to, s_idle, s_empty, s_stall, s_ready;
    logic [31:0] s_addr, s_data;
    logic [3:0]  s_strb;

    // Reference: store transformation from the access rules, plain arithmetic.
    function automatic void model_store(input store_buffer_entry_t e, output exp_t x, output bit bad);
        int unsigned off;
        off = e.address % 4;
        x.a = e.address - off;
        case (e.store_width)
            BYTE: begin x.s = 4'(1 << off); x.d = {24'h0, e.data[7:0]} * 32'h01010101; bad = 1'b0; end
            HALF: begin x.s = 4'(3 << off); x.d = {16'h0, e.data[15:0]} * 32'h00010001; bad = (off % 2) != 0; end
            default: begin x.s = 4'hF; x.d = e.data; bad = (off != 0); end
        endcase
    endfunction

    task automatic drive_fifo();
        pif.empty  = (fifo.size() == 0);
        pif.packet = (fifo.size() != 0) ? fifo[0] : '0;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d, input store_width_t w);
        store_buffer_entry_t e;
        e.address = a; e.data = d; e.store_width = w;
        fifo.push_back(e);
        drive_fifo();
    endtask

    // Sample the current cycle at the falling edge, then advance past the
    // next rising edge; the buffer model pops what the DUT pulled.
    task automatic step();
        @(negedge clk);
        s_pull  = pif.pull_request; s_valid = valid; s_mis = mis; s_to = tmo;
        s_idle  = idle; s_empty = pif.empty; s_stall = stall; s_ready = ready;
        s_addr  = addr; s_data = data; s_strb = strb;
        if (s_pull) pulls++;
        @(posedge clk);
        #1;
        if (s_pull && fifo.size() > 0) void'(fifo.pop_front());
        drive_fifo();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; stall = 1'b0; ready = 1'b0; done = 1'b0;
        fifo.delete(); drive_fifo();
        step(); step();
        checks++;
        if ({s_valid, s_mis, s_to, s_pull} !== 4'b0000 || s_addr !== 32'h0 || s_data !== 32'h0 || s_strb !== 4'h0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b m=%b t=%b p=%b a=%h d=%h s=%h, want all 0", s_valid, s_mis, s_to, s_pull, s_addr, s_data, s_strb);
        end
        checks++;
        if (s_idle !== 1'b1) begin errors++; $display("FAIL reset_idle_empty: got %b want 1", s_idle); end
        push(32'h0, 32'h0, WORD);
        step();
        checks++;
        if (s_idle !== 1'b0 || s_pull !== 1'b0) begin
            errors++; $display("FAIL reset_idle_follows_empty: got idle=%b pull=%b want 0 0", s_idle, s_pull);
        end
        fifo.delete(); drive_fifo();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_word();
        int unsigned p0;
        p0 = pulls;
        ready = 1'b1;
        push(32'h100, 32'hDEADBEEF, WORD);
        step();
        checks++;
        if (s_pull !== 1'b1 || s_valid !== 1'b0) begin errors++; $display("FAIL word_pull: got pull=%b valid=%b want 1 0", s_pull, s_valid); end
        step();
        checks++;
        if (s_valid !== 1'b1 || s_addr !== 32'h100 || s_strb !== 4'hF || s_data !== 32'hDEADBEEF) begin
            errors++; $display("FAIL word_issue: got v=%b a=%h s=%h d=%h want 1 00000100 f deadbeef", s_valid, s_addr, s_strb, s_data);
        end
        step(); step();
        checks++;
        if (s_valid !== 1'b0 || s_idle !== 1'b0) begin errors++; $display("FAIL word_wait: got v=%b idle=%b want 0 0", s_valid, s_idle); end
        done = 1'b1;
        step();
        done = 1'b0;
        step();
        checks++;
        if (s_idle !== 1'b1 || s_to !== 1'b0 || pulls - p0 != 1) begin
            errors++; $display("FAIL word_complete: got idle=%b to=%b pulls=%0d want 1 0 1", s_idle, s_to, pulls - p0);
        end
        ready = 1'b0;
    endtask

    task automatic test_byte();
        ready = 1'b1;
        push(32'h203, 32'h000000AB, BYTE);
        step(); step();
        checks++;
        if (s_valid !== 1'b1 || s_addr !== 32'h200 || s_strb !== 4'b1000 || s_data !== 32'hABABABAB) begin
            errors++; $display("FAIL byte_issue: got v=%b a=%h s=%b d=%h want 1 00000200 1000 abababab", s_valid, s_addr, s_strb, s_data);
        end
        done = 1'b1;
        step();
        done = 1'b0;
        step();
        checks++;
        if (s_idle !== 1'b1) begin errors++; $display("FAIL byte_complete: got idle=%b want 1", s_idle); end
        ready = 1'b0;
    endtask

    task automatic test_misaligned();
        store_buffer_entry_t e;
        exp_t x;
        bit   bad;
        int   nmis = 0, nval = 0;
        e.address = 32'h301; e.data = 32'h1234; e.store_width = HALF;
        model_store(e, x, bad);
        push(e.address, e.data, e.store_width);
        ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            if (s_mis) nmis++;
            if (s_valid) nval++;
        end
        checks++;
        if (nmis != (bad ? 1 : 0) || nval != 0 || fifo.size() != 0) begin
            errors++; $display("FAIL misaligned_drop: got pulses=%0d valid=%0d left=%0d want %0d 0 0", nmis, nval, fifo.size(), bad ? 1 : 0);
        end
        ready = 1'b0;
    endtask

    task automatic test_done_ignored();
        ready = 1'b0;
        done  = 1'b1;
        step();
        checks++;
        if (s_idle !== 1'b1 || s_valid !== 1'b0) begin errors++; $display("FAIL done_in_idle: got idle=%b v=%b want 1 0", s_idle, s_valid); end
        push(32'h500, 32'h5A5A0001, WORD);
        step(); step(); step();
        checks++;
        if (s_valid !== 1'b1 || s_addr !== 32'h500) begin errors++; $display("FAIL valid_hold: got v=%b a=%h want 1 00000500", s_valid, s_addr); end
        done  = 1'b0;
        ready = 1'b1;
        step();
        ready = 1'b0;
        done  = 1'b1;
        step();
        done  = 1'b0;
        step();
        checks++;
        if (s_idle !== 1'b1) begin errors++; $display("FAIL done_after_hold: got idle=%b want 1", s_idle); end
    endtask

    task automatic test_back_to_back();
        int   pc[$];
        int   acc = 0, gaps = 0;
        exp_t x;
        bit   bad;
        store_buffer_entry_t e;
        ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            e.address = 32'h400 + 32'(4 * i); e.data = $urandom; e.store_width = WORD;
            model_store(e, x, bad);
            expq.push_back(x);
            push(e.address, e.data, e.store_width);
        end
        for (int c = 0; c < 12; c++) begin
            step();
            if (s_pull) pc.push_back(c);
            if (acc < 3 && s_idle) gaps++;
            if (s_valid && expq.size() > 0) begin
                x = expq.pop_front();
                acc++;
                checks++;
                if (s_addr !== x.a || s_data !== x.d || s_strb !== x.s) begin
                    errors++; $display("FAIL b2b_store: got a=%h d=%h s=%h want %h %h %h", s_addr, s_data, s_strb, x.a, x.d, x.s);
                end
            end
            done = s_valid;
        end
        done = 1'b0;
        checks++;
        if (pc.size() != 3 || acc != 3 || gaps != 0) begin
            errors++; $display("FAIL b2b_count: got pulls=%0d stores=%0d idle_gaps=%0d want 3 3 0", pc.size(), acc, gaps);
        end else begin
            checks++;
            if (pc[1] - pc[0] != 2 || pc[2] - pc[1] != 2) begin
                errors++; $display("FAIL b2b_spacing: got %0d %0d want 2 2", pc[1] - pc[0], pc[2] - pc[1]);
            end
        end
        expq.delete();
        ready = 1'b0;
    endtask

    task automatic test_timeout(input bit done_at_expiry);
        int first = -1, n = 0;
        bit idle_at = 1'b0;
        ready = 1'b1;
        push(32'h600, 32'h0000CAFE, WORD);
        step(); step();
        ready = 1'b0;
        // Now in the first WAIT_DONE cycle (offset 0).
        for (int k = 0; k < 7; k++) begin
            done = done_at_expiry && (k == int'(TO) - 1);
            step();
            if (s_to) begin n++; if (first < 0) first = k; end
            if (k == int'(TO)) idle_at = s_idle;
        end
        done = 1'b0;
        if (!done_at_expiry) begin
            checks++;
            if (n != 1 || first != int'(TO)) begin
                errors++; $display("FAIL timeout_pulse: got pulses=%0d at=%0d want 1 at %0d", n, first, TO);
            end
        end else begin
            checks++;
            if (n != 0) begin errors++; $display("FAIL done_at_expiry: got %0d timeout pulses want 0", n); end
        end
        checks++;
        if (idle_at !== 1'b1) begin errors++; $display("FAIL timeout_idle: got idle=%b want 1", idle_at); end
    endtask

    task automatic test_stall_and_reset();
        int bad_pull = 0, extra = 0;
        stall = 1'b1;
        push(32'h700, 32'h77777777, WORD);
        for (int i = 0; i < 3; i++) begin
            step();
            if (s_pull || s_valid || s_idle) bad_pull++;
        end
        checks++;
        if (bad_pull != 0) begin errors++; $display("FAIL stall_blocks: got %0d bad cycles want 0", bad_pull); end
        stall = 1'b0;
        step();
        checks++;
        if (s_pull !== 1'b1) begin errors++; $display("FAIL stall_release: got pull=%b want 1", s_pull); end
        ready = 1'b1;
        step();
        ready = 1'b0;
        stall = 1'b1;
        rst_n = 1'b0;
        step();
        step();
        checks++;
        if ({s_valid, s_mis, s_to, s_pull} !== 4'b0000 || s_addr !== 32'h0 || s_data !== 32'h0 || s_strb !== 4'h0 || s_idle !== 1'b1) begin
            errors++; $display("FAIL reset_in_wait: got v=%b m=%b t=%b p=%b a=%h d=%h s=%h idle=%b want zeros idle=1",
                               s_valid, s_mis, s_to, s_pull, s_addr, s_data, s_strb, s_idle);
        end
        rst_n = 1'b1;
        stall = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (s_to || s_mis || s_valid) extra++;
        end
        checks++;
        if (extra != 0) begin errors++; $display("FAIL reset_lost_entry: got %0d pulses/valids want 0", extra); end
    endtask

    task automatic test_random();
        localparam int N = 40;
        int   pushed = 0, mis_exp = 0, mis_seen = 0, dcnt = -1, cyc = 0;
        bit   finished = 1'b0, prev_hold = 1'b0, bad;
        exp_t x, held;
        store_buffer_entry_t e;
        while (cyc < 3000 && !finished) begin
            if (pushed < N && $urandom_range(0, 2) == 0) begin
                e.address = $urandom; e.data = $urandom; e.store_width = store_width_t'($urandom_range(0, 2));
                if ($urandom_range(0, 1) == 1) e.address[1:0] = 2'b00;
                model_store(e, x, bad);
                if (bad) mis_exp++; else expq.push_back(x);
                push(e.address, e.data, e.store_width);
                pushed++;
            end
            done = (dcnt == 0);
            if (dcnt >= 0) dcnt--;
            stall = ($urandom_range(0, 3) == 0);
            ready = $urandom_range(0, 1);
            step();
            cyc++;
            if (s_pull) begin
                checks++;
                if (s_empty || s_stall || s_valid) begin
                    errors++; $display("FAIL rand_pull_rule: pull with empty=%b stall=%b valid=%b", s_empty, s_stall, s_valid);
                end
            end
            if (prev_hold) begin
                checks++;
                if (s_valid !== 1'b1 || s_addr !== held.a || s_data !== held.d || s_strb !== held.s) begin
                    errors++; $display("FAIL rand_hold: got v=%b a=%h d=%h s=%h want 1 %h %h %h", s_valid, s_addr, s_data, s_strb, held.a, held.d, held.s);
                end
            end
            prev_hold = s_valid && !s_ready;
            held.a = s_addr; held.d = s_data; held.s = s_strb;
            if (s_mis) mis_seen++;
            if (s_to) begin checks++; errors++; $display("FAIL rand_timeout: unexpected timeout_o at cycle %0d", cyc); end
            if (s_valid && s_ready) begin
                dcnt = $urandom_range(0, int'(TO) - 1);
                checks++;
                if (expq.size() == 0) begin
                    errors++; $display("FAIL rand_store: got a=%h with no store expected", s_addr);
                end else begin
                    x = expq.pop_front();
                    if (s_addr !== x.a || s_data !== x.d || s_strb !== x.s) begin
                        errors++; $display("FAIL rand_store: got a=%h d=%h s=%h want %h %h %h", s_addr, s_data, s_strb, x.a, x.d, x.s);
                    end
                end
            end
            finished = (pushed == N) && (expq.size() == 0) && (fifo.size() == 0) && (dcnt < 0) && s_idle;
        end
        done = 1'b0; stall = 1'b0; ready = 1'b0;
        checks++;
        if (!finished || mis_seen != mis_exp) begin
            errors++; $display("FAIL rand_drain: finished=%b left=%0d misaligned got %0d want %0d", finished, expq.size(), mis_seen, mis_exp);
        end
        expq.delete();
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte();
        test_misaligned();
        test_done_ignored();
        test_back_to_back();
        test_timeout(1'b0);
        test_timeout(1'b1);
        test_stall_and_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
